// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: field/control decode, ID/EX register, valid/ready
// handshakes, load-use stall and a saturating stall counter. Macro DS_ILLEGAL_TRAP_EN adds ds_o_illegal.
module decode_stage #(
    parameter int IWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
) (
    input  logic              ds_i_clk,
    input  logic              ds_i_rst,
    input  logic              ds_i_valid,
    output logic              ds_o_ready,
    input  logic [IWIDTH-1:0] ds_i_instr,
    input  logic              ds_i_flush,
    output logic              ds_o_valid,
    input  logic              ds_i_ready,
    output logic [5:0]        ds_o_opcode,
    output logic [5:0]        ds_o_funct,
    output logic [4:0]        ds_o_shamt,
    output logic [AWIDTH-1:0] ds_o_addr_rs,
    output logic [AWIDTH-1:0] ds_o_addr_rt,
    output logic [AWIDTH-1:0] ds_o_addr_wr,
    output logic [DWIDTH-1:0] ds_o_imm,
    output logic              ds_o_alu_src,
    output logic              ds_o_branch,
    output logic              ds_o_reg_wr,
    output logic              ds_o_memread,
    output logic              ds_o_memwrite,
    output logic              ds_o_memtoreg,
    output logic [CWIDTH-1:0] ds_o_stall_cnt
`ifdef DS_ILLEGAL_TRAP_EN
    ,
    output logic              ds_o_illegal
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW   = 6'h23, OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E;
`ifdef DS_ILLEGAL_TRAP_EN
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
`endif

    typedef struct packed {
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [4:0]        shamt;
        logic [AWIDTH-1:0] rs;
        logic [AWIDTH-1:0] rt;
        logic [AWIDTH-1:0] wr;
        logic [DWIDTH-1:0] imm;
        logic              alu_src;
        logic              branch;
        logic              reg_wr;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
    } idex_t;

    // A bubble or emptied register keeps its fields but must never look like a live control.
    function automatic idex_t kill_ctrl(input idex_t x);
        idex_t y;
        y          = x;
        y.alu_src  = 1'b0;
        y.branch   = 1'b0;
        y.reg_wr   = 1'b0;
        y.memread  = 1'b0;
        y.memwrite = 1'b0;
        y.memtoreg = 1'b0;
        return y;
    endfunction

    logic [31:0]       ins;
    logic [DWIDTH-1:0] imm_sx, imm_zx;
    logic [AWIDTH-1:0] in_rs, in_rt, in_rd;
    idex_t             dec, idex_d, idex_q;
    logic              in_uses_rt, haz, hold, trap;
    logic              vld_d, vld_q;
    logic [CWIDTH-1:0] cnt_d, cnt_q;
`ifdef DS_ILLEGAL_TRAP_EN
    logic              dec_ill, ill_d, ill_q;
`endif

    assign ins    = ds_i_instr[31:0];
    assign in_rs  = AWIDTH'(ins[25:21]);
    assign in_rt  = AWIDTH'(ins[20:16]);
    assign in_rd  = AWIDTH'(ins[15:11]);
    assign imm_sx = {{(DWIDTH-16){ins[15]}}, ins[15:0]};
    assign imm_zx = {{(DWIDTH-16){1'b0}}, ins[15:0]};

    always_comb begin
        dec        = '0;
        in_uses_rt = 1'b0;
`ifdef DS_ILLEGAL_TRAP_EN
        dec_ill    = 1'b0;
`endif
        dec.opcode = ins[31:26];
        case (ins[31:26])
            OP_RTYPE: begin
                dec.funct  = ins[5:0];
                dec.shamt  = ins[10:6];
                dec.rs     = in_rs;
                dec.rt     = in_rt;
                dec.wr     = in_rd;
                dec.reg_wr = 1'b1;
                in_uses_rt = 1'b1;
            end
            OP_LW: begin
                dec.rs       = in_rs;
                dec.rt       = in_rt;
                dec.wr       = in_rt;
                dec.imm      = imm_sx;
                dec.alu_src  = 1'b1;
                dec.reg_wr   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
            end
            OP_SW: begin
                dec.rs       = in_rs;
                dec.rt       = in_rt;
                dec.imm      = imm_sx;
                dec.alu_src  = 1'b1;
                dec.memwrite = 1'b1;
                in_uses_rt   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.rs     = in_rs;
                dec.rt     = in_rt;
                dec.imm    = imm_sx;
                dec.branch = 1'b1;
                in_uses_rt = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.rs      = in_rs;
                dec.rt      = in_rt;
                dec.wr      = in_rt;
                dec.imm     = (ins[31:26] >= OP_ANDI) ? imm_zx : imm_sx;
                dec.alu_src = 1'b1;
                dec.reg_wr  = 1'b1;
            end
            default: begin
`ifdef DS_ILLEGAL_TRAP_EN
                dec_ill = 1'b1;
`endif
            end
        endcase
`ifdef DS_ILLEGAL_TRAP_EN
        if (ins[31:26] == OP_RTYPE && !(ins[5:0] inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR})) begin
            dec        = '0;
            dec.opcode = ins[31:26];
            dec_ill    = 1'b1;
        end
`endif
        if (dec.wr == '0) dec.reg_wr = 1'b0;
    end

    // Load-use: the load in ID/EX has not produced data yet for a dependent instruction.
    assign haz  = vld_q & idex_q.memread & (idex_q.wr != '0) & ds_i_valid &
                  ((in_rs == idex_q.wr) | (in_uses_rt & (in_rt == idex_q.wr)));
    assign hold = vld_q & ~ds_i_ready;
`ifdef DS_ILLEGAL_TRAP_EN
    assign trap = ill_q;
`else
    assign trap = 1'b0;
`endif
    assign ds_o_ready = ds_i_rst & ~ds_i_flush & ~haz & ~hold & ~trap;

    always_comb begin
        idex_d = idex_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
`ifdef DS_ILLEGAL_TRAP_EN
        ill_d  = ill_q;
`endif
        if (ds_i_flush) begin
            vld_d  = 1'b0;
            idex_d = kill_ctrl(idex_q);
`ifdef DS_ILLEGAL_TRAP_EN
            ill_d  = 1'b0;
`endif
        end else if (hold) begin
            vld_d = vld_q;
        end else if (haz) begin
            vld_d  = 1'b0;
            idex_d = kill_ctrl(idex_q);
            if (cnt_q != '1) cnt_d = cnt_q + CWIDTH'(1);
        end else if (ds_i_valid && !trap) begin
            vld_d  = 1'b1;
            idex_d = dec;
`ifdef DS_ILLEGAL_TRAP_EN
            ill_d  = dec_ill;
`endif
        end else begin
            vld_d  = 1'b0;
            idex_d = kill_ctrl(idex_q);
        end
    end

    always_ff @(posedge ds_i_clk or negedge ds_i_rst) begin
        if (!ds_i_rst) begin
            idex_q <= '0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
`ifdef DS_ILLEGAL_TRAP_EN
            ill_q  <= 1'b0;
`endif
        end else begin
            idex_q <= idex_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
`ifdef DS_ILLEGAL_TRAP_EN
            ill_q  <= ill_d;
`endif
        end
    end

`ifdef DS_ILLEGAL_TRAP_EN
    assign ds_o_illegal = ill_q;
`endif
    assign ds_o_valid     = vld_q;
    assign ds_o_opcode    = idex_q.opcode;
    assign ds_o_funct     = idex_q.funct;
    assign ds_o_shamt     = idex_q.shamt;
    assign ds_o_addr_rs   = idex_q.rs;
    assign ds_o_addr_rt   = idex_q.rt;
    assign ds_o_addr_wr   = idex_q.wr;
    assign ds_o_imm       = idex_q.imm;
    assign ds_o_alu_src   = idex_q.alu_src;
    assign ds_o_branch    = idex_q.branch;
    assign ds_o_reg_wr    = idex_q.reg_wr;
    assign ds_o_memread   = idex_q.memread;
    assign ds_o_memwrite  = idex_q.memwrite;
    assign ds_o_memtoreg  = idex_q.memtoreg;
    assign ds_o_stall_cnt = cnt_q;

endmodule
